// File: rtl/aes_pkg.sv
// AES primitives shared by the streaming encryptor: S-box, GF(2^8) helpers,
// round transforms, Rcon table and key-length decoding.
package aes_pkg;
  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_BAD = 2'b11;

  localparam logic [10:0][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [3:0] nk_of(input logic [1:0] kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as affine(x^254): the chain builds x^127, one more square gives the inverse
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t, v;
    t = x;
    for (int k = 0; k < 6; k++) t = gmul(gmul(t, t), x);
    v = gmul(t, t);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = sub_word(s[32*k +: 32]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++)
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = a;
    t = a0 ^ a1 ^ a2 ^ a3;
    return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
            a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = mix_column(s[32*k +: 32]);
    return r;
  endfunction
endpackage

// File: rtl/aes_key_step.sv
// Produces the next four expanded key words from the last eight.
// win[0] is word idx-1 (newest), win[7] is word idx-8; nw[0] is word idx.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [7:0][31:0] win,
  input  logic [3:0]       nk,
  input  logic [5:0]       idx,
  output logic [0:3][31:0] nw
);
  logic [31:0] prev, t, w;
  logic [5:0]  i, m, d;
  logic [2:0]  sel;
  logic [7:0]  rc;

  always_comb begin
    nw   = '0;
    prev = win[0];
    t    = '0;
    w    = '0;
    i    = '0;
    m    = '0;
    d    = '0;
    sel  = '0;
    rc   = '0;
    for (int j = 0; j < 4; j++) begin
      i   = idx + 6'(j);
      m   = i % {2'b00, nk};
      d   = i / {2'b00, nk};
      rc  = (d <= 6'd10) ? RCON[d[3:0]] : 8'h00;
      // word i-Nk always sits in the window since Nk >= 4
      sel = 3'(nk - 4'(j + 1));
      if (m == 6'd0)                    t = sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h0};
      else if (nk == 4'd8 && m == 6'd4) t = sub_word(prev);
      else                              t = prev;
      w     = win[sel] ^ t;
      nw[j] = w;
      prev  = w;
    end
  end
endmodule

// File: rtl/aes_enc_stream.sv
// Iterative AES-128/192/256 encryptor, one round per clock, on-the-fly key
// expansion and a small ciphertext FIFO on the output.
module aes_enc_stream
  import aes_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [255:0] in_key,
  input  logic [1:0]   in_key_len,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  input  logic         flush,
  output logic         err_key_len,
  output logic         busy
);
  localparam int AW = $clog2(OUT_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} st_t;
  st_t st, st_nxt;

  logic [127:0]      aes_st, rk, sr, rnd_full, rnd_last;
  logic [3:0]        rnd, nr, nk;
  logic [1:0]        kl;
  logic [7:0][31:0]  win;
  logic [255:0]      win_init;
  logic [5:0]        gidx;
  logic [0:3][31:0]  nw;
  logic [127:0]      mem [OUT_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              accept, legal, push, pop;

  assign in_ready  = reset_n && (st == IDLE) && (cnt < CW'(OUT_DEPTH)) && !flush;
  assign accept    = in_valid && in_ready;
  assign legal     = in_key_len != KL_BAD;
  assign push      = (st == FINAL) && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign out_valid = cnt != '0;
  assign out_data  = mem[rd_ptr];
  assign busy      = st != IDLE;
  assign nk        = nk_of(kl);

  aes_key_step u_key (.win(win), .nk(nk), .idx(gidx), .nw(nw));

  // Window is right-aligned so the newest key word always lands in win[0]
  always_comb begin
    case (in_key_len)
      KL_192:  win_init = {64'h0, in_key[255:64]};
      KL_256:  win_init = in_key;
      default: win_init = {128'h0, in_key[255:128]};
    endcase
  end

  always_comb begin
    case (kl)
      KL_192:  rk = {win[1:0], nw[0:1]};
      KL_256:  rk = win[3:0];
      default: rk = nw;
    endcase
    sr       = shift_rows(sub_bytes(aes_st));
    rnd_full = mix_columns(sr) ^ rk;
    rnd_last = sr ^ rk;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st <= IDLE;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (flush) st_nxt = IDLE;
    else begin
      case (st)
        IDLE:    if (accept && legal) st_nxt = ROUND;
        ROUND:   if (rnd == nr - 4'd1) st_nxt = FINAL;
        FINAL:   st_nxt = IDLE;
        default: st_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aes_st      <= '0;
      rnd         <= '0;
      nr          <= 4'd10;
      kl          <= KL_128;
      win         <= '0;
      gidx        <= '0;
      err_key_len <= 1'b0;
    end else begin
      err_key_len <= accept && !legal;
      if (accept && legal) begin
        aes_st <= in_data ^ in_key[255:128];
        rnd    <= 4'd1;
        nr     <= nr_of(in_key_len);
        kl     <= in_key_len;
        win    <= win_init;
        gidx   <= {2'b00, nk_of(in_key_len)};
      end else if (st != IDLE) begin
        aes_st <= rnd_full;
        rnd    <= rnd + 4'd1;
        win    <= {win[3:0], nw};
        gidx   <= gidx + 6'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rnd_last;
  end
endmodule
